// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO read and write controllers.
//   ADDR_WIDTH_DEF : default RAM address width (depth = 2**ADDR_WIDTH_DEF)
//   PTR_WIDTH_DEF  : default pointer width (one extra wrap bit)
//   ptr_t          : pointer type at the default width
//   bin2gray()     : binary to reflected-Gray conversion
// Optional feature macro used by the controllers: RD_UNDERFLOW_EN
// ----------------------------------------------------------------------------
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int PTR_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;

  typedef logic [PTR_WIDTH_DEF-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// ----------------------------------------------------------------------------
// gray_to_bin
// Purely combinational Gray-to-binary converter, shared by the read-side
// level logic and the write-side full/level logic.
//   W       : pointer width
//   i_gray  : Gray-coded input
//   o_bin   : binary output
// Each binary bit is the XOR of all Gray bits from the MSB down to itself.
// ----------------------------------------------------------------------------
module gray_to_bin
  import fifo_pkg::*;
#(
  parameter int W = PTR_WIDTH_DEF
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[W-1:gi];
    end
  endgenerate

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_rd_ptr_ctrl
// Read-domain pointer and status controller for the asynchronous FIFO.
//   i_clk               : read-domain clock
//   i_rst_n             : asynchronous active-low reset
//   i_rd_en             : read request from the consumer
//   i_wr_ptr_gray_sync  : Gray write pointer, already synchronized to i_clk
//   o_rd_addr           : RAM read address (low bits of binary read pointer)
//   o_rd_ptr_gray       : registered Gray read pointer for the write side
//   o_empty             : registered empty flag
//   o_almost_empty      : registered, high when level <= AE_THRESH
//   o_rd_level          : registered occupancy seen from the read domain
//   o_rd_underflow      : sticky read-while-empty flag (only with the
//                         RD_UNDERFLOW_EN macro defined)
// Flags and level are computed from the next-state pointer so they agree
// with the pointer on the same edge. Synchronizer lag keeps them pessimistic.
// ----------------------------------------------------------------------------
module fifo_rd_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int Addr_width = ADDR_WIDTH_DEF,
  parameter int AE_THRESH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rd_en,
  input  logic [Addr_width:0]   i_wr_ptr_gray_sync,
  output logic [Addr_width-1:0] o_rd_addr,
  output logic [Addr_width:0]   o_rd_ptr_gray,
  output logic                  o_empty,
  output logic                  o_almost_empty,
`ifdef RD_UNDERFLOW_EN
  output logic                  o_rd_underflow,
`endif
  output logic [Addr_width:0]   o_rd_level
);

  localparam int PW = Addr_width + 1;

  logic [PW-1:0] r_rd_bin;
  logic [PW-1:0] r_rd_ptr_gray;
  logic [PW-1:0] r_rd_level;
  logic          r_empty;
  logic          r_almost_empty;

  logic          w_rd_acc;
  logic [PW-1:0] w_rd_bin_next;
  logic [PW-1:0] w_rd_gray_next;
  logic [PW-1:0] w_wr_bin_sync;
  logic [PW-1:0] w_level_next;

  // Reads while empty are dropped; the pointer never passes the write pointer.
  assign w_rd_acc      = i_rd_en & ~r_empty;
  assign w_rd_bin_next = r_rd_bin + PW'(w_rd_acc);

  // The shared package helper is sized for the default width only.
  generate
    if (Addr_width == ADDR_WIDTH_DEF) begin : g_pkg_gray
      assign w_rd_gray_next = bin2gray(w_rd_bin_next);
    end else begin : g_local_gray
      assign w_rd_gray_next = w_rd_bin_next ^ (w_rd_bin_next >> 1);
    end
  endgenerate

  gray_to_bin #(
    .W (PW)
  ) u_wr_g2b (
    .i_gray (i_wr_ptr_gray_sync),
    .o_bin  (w_wr_bin_sync)
  );

  // Modulo subtraction: the wrap bit makes a full FIFO read as 2**Addr_width.
  assign w_level_next = w_wr_bin_sync - w_rd_bin_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_bin       <= '0;
      r_rd_ptr_gray  <= '0;
      r_rd_level     <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
    end else begin
      r_rd_bin       <= w_rd_bin_next;
      r_rd_ptr_gray  <= w_rd_gray_next;
      r_rd_level     <= w_level_next;
      r_empty        <= (w_rd_gray_next == i_wr_ptr_gray_sync);
      r_almost_empty <= (w_level_next <= PW'(AE_THRESH));
    end
  end

`ifdef RD_UNDERFLOW_EN
  logic r_rd_underflow;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_underflow <= 1'b0;
    end else if (i_rd_en && r_empty) begin
      r_rd_underflow <= 1'b1;
    end
  end

  assign o_rd_underflow = r_rd_underflow;
`endif

  assign o_rd_addr      = r_rd_bin[Addr_width-1:0];
  assign o_rd_ptr_gray  = r_rd_ptr_gray;
  assign o_empty        = r_empty;
  assign o_almost_empty = r_almost_empty;
  assign o_rd_level     = r_rd_level;

endmodule
